// File: rtl/bus_arbiter.sv
// Two-requester bus arbiter: alternating tie-break, bounded hold with forced
// handoff, and a registered grant/select pair driving a combinational data mux.
module bus_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_HOLD   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  select,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    output logic [7:0]            hold_cnt
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_srv;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= HOLD_MAX) ? HOLD_MAX : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            select   <= 1'b0;
            last_srv <= 1'b1;
            hold_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie, the side that was not served last wins.
                    if (req0 && (!req1 || last_srv)) begin
                        state    <= GRANT0;
                        gnt0     <= 1'b1;
                        gnt1     <= 1'b0;
                        select   <= 1'b0;
                        last_srv <= 1'b0;
                        hold_cnt <= 8'd1;
                    end else if (req1) begin
                        state    <= GRANT1;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b1;
                        select   <= 1'b1;
                        last_srv <= 1'b1;
                        hold_cnt <= 8'd1;
                    end else begin
                        hold_cnt <= 8'd0;
                    end
                end
                GRANT0: begin
                    if (req1 && (!req0 || hold_cnt == HOLD_MAX)) begin
                        state    <= GRANT1;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b1;
                        select   <= 1'b1;
                        last_srv <= 1'b1;
                        hold_cnt <= 8'd1;
                    end else if (!req0) begin
                        state    <= IDLE;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b0;
                        hold_cnt <= 8'd0;
                    end else begin
                        hold_cnt <= sat_inc(hold_cnt);
                    end
                end
                GRANT1: begin
                    if (req0 && (!req1 || hold_cnt == HOLD_MAX)) begin
                        state    <= GRANT0;
                        gnt0     <= 1'b1;
                        gnt1     <= 1'b0;
                        select   <= 1'b0;
                        last_srv <= 1'b0;
                        hold_cnt <= 8'd1;
                    end else if (!req1) begin
                        state    <= IDLE;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b0;
                        hold_cnt <= 8'd0;
                    end else begin
                        hold_cnt <= sat_inc(hold_cnt);
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    hold_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign out       = select ? data1 : data0;
    assign out_valid = (gnt0 & req0) | (gnt1 & req1);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random stimulus for bus_arbiter, checked against a reference
// model whose expected post-edge values are queued at drive time.
module tb_bus_arbiter;

    localparam int         MAXH  = 8;
    localparam logic [7:0] MAXH8 = 8'(MAXH);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] data0 = 16'h0;
    logic [15:0] data1 = 16'h0;
    logic        gnt0, gnt1, select, out_valid;
    logic [15:0] out;
    logic [7:0]  hold_cnt;

    bus_arbiter #(.DATA_WIDTH(16), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
        .select(select), .out(out), .out_valid(out_valid), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic       sel;
        logic [7:0] hold;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int wait0    = 0;
    int wait1    = 0;

    // Reference model state: 0 idle, 1 granted to 0, 2 granted to 1
    int         m_state;
    logic       m_last;
    logic       m_sel;
    logic [7:0] m_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
            $error("check %s miscompared", tag);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_last  = 1'b1;
        m_sel   = 1'b0;
        m_hold  = 8'd0;
    endtask

    task automatic model_grant(input logic x);
        m_state = x ? 2 : 1;
        m_sel   = x;
        m_last  = x;
        m_hold  = 8'd1;
    endtask

    task automatic model_advance(input string tag, input logic r0, input logic r1);
        logic cur, own, oth;
        exp_t e;
        if (m_state == 0) begin
            if (r0 || r1) model_grant((r0 && r1) ? ~m_last : r1);
            else m_hold = 8'd0;
        end else begin
            cur = (m_state == 2);
            own = cur ? r1 : r0;
            oth = cur ? r0 : r1;
            if (oth && (!own || m_hold == MAXH8)) model_grant(~cur);
            else if (!own) begin
                m_state = 0;
                m_hold  = 8'd0;
            end else if (m_hold < MAXH8) m_hold = m_hold + 8'd1;
        end
        e.g0   = (m_state == 1);
        e.g1   = (m_state == 2);
        e.sel  = m_sel;
        e.hold = m_hold;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_sb();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, "_gnt0"}, 32'(gnt0), 32'(e.g0));
            check({t, "_gnt1"}, 32'(gnt1), 32'(e.g1));
            check({t, "_select"}, 32'(select), 32'(e.sel));
            check({t, "_hold"}, 32'(hold_cnt), 32'(e.hold));
        end
        check({t, "_excl"}, 32'(gnt0 & gnt1), 32'd0);
        if (gnt0 | gnt1) check({t, "_selmatch"}, 32'(select), 32'(gnt1));
    endtask

    task automatic step(input string tag, input logic r0, input logic r1,
                        input logic [15:0] d0, input logic [15:0] d1);
        @(negedge clk);
        req0  = r0;
        req1  = r1;
        data0 = d0;
        data1 = d1;
        #1;
        check({tag, "_out"}, 32'(out), 32'(m_sel ? d1 : d0));
        check({tag, "_oval"}, 32'(out_valid), 32'((m_state == 1 && r0) || (m_state == 2 && r1)));
        model_advance(tag, r0, r1);
        @(posedge clk);
        #1;
        compare_sb();
        wait0 = (r0 && !gnt0) ? wait0 + 1 : 0;
        wait1 = (r1 && !gnt1) ? wait1 + 1 : 0;
        check({tag, "_wait0"}, 32'(wait0 <= MAXH + 2), 32'd1);
        check({tag, "_wait1"}, 32'(wait1 <= MAXH + 2), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt0"}, 32'(gnt0), 32'd0);
        check({tag, "_gnt1"}, 32'(gnt1), 32'd0);
        check({tag, "_select"}, 32'(select), 32'd0);
        check({tag, "_hold"}, 32'(hold_cnt), 32'd0);
    endtask

    // Reset held across several edges with both requests pending
    task automatic reset_hold(input int edges);
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b1;
        rst  = 1'b1;
        #1;
        check_reset_vals("rst_async");
        model_reset();
        wait0 = 0;
        wait1 = 0;
        repeat (edges) begin
            @(posedge clk);
            #1;
            check_reset_vals("rst_held");
        end
        @(negedge clk);
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: observed still running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int g0_cycles;
        logic r0, r1;

        model_reset();
        reset_hold(3);

        step("grant0", 1'b1, 1'b0, 16'hA5A5, 16'h0000);
        check("r31_gnt0", 32'(gnt0), 32'd1);
        check("r31_sel", 32'(select), 32'd0);
        check("r31_out", 32'(out), 32'h0000A5A5);
        check("r31_oval", 32'(out_valid), 32'd1);
        check("r31_hold", 32'(hold_cnt), 32'd1);

        reset_hold(1);
        step("tie", 1'b1, 1'b1, 16'h1111, 16'h2222);
        check("r32_tie_gnt0", 32'(gnt0), 32'd1);
        step("release", 1'b0, 1'b1, 16'h1111, 16'h2222);
        check("r32_gnt1", 32'(gnt1), 32'd1);
        check("r32_sel", 32'(select), 32'd1);
        check("r32_out", 32'(out), 32'h00002222);
        step("idle", 1'b0, 1'b0, 16'h3333, 16'h4444);
        check("idle_sel_held", 32'(select), 32'd1);
        check("idle_hold", 32'(hold_cnt), 32'd0);

        g0_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            step("hold_a", 1'b1, 1'b0, 16'h5555, 16'h6666);
            if (gnt0) g0_cycles++;
        end
        check("r33_hold3", 32'(hold_cnt), 32'd3);
        for (int i = 0; i < 6; i++) begin
            step("hold_b", 1'b1, 1'b1, 16'h5555, 16'h6666);
            if (gnt0) g0_cycles++;
        end
        check("r33_g0_cycles", 32'(g0_cycles), 32'd8);
        check("r33_handoff_gnt1", 32'(gnt1), 32'd1);
        check("r33_handoff_hold", 32'(hold_cnt), 32'd1);

        step("drop0", 1'b0, 1'b1, 16'h7777, 16'h8888);
        for (int i = 0; i < 20; i++) begin
            step("solo1", 1'b0, 1'b1, 16'h7777, 16'h8888);
            check("r34_gnt1", 32'(gnt1), 32'd1);
        end
        check("r34_sat", 32'(hold_cnt), 32'd8);

        // Asynchronous pulse between edges while in GRANT1
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_vals("r35_pulse");
        #1 rst = 1'b0;
        model_reset();
        wait0 = 0;
        wait1 = 0;
        model_advance("r35_after", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        compare_sb();
        check("r35_gnt0", 32'(gnt0), 32'd1);

        step("to_idle", 1'b0, 1'b0, 16'h0, 16'h0);

        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(3) == 0) r0 = ~r0;
            if ($urandom_range(3) == 0) r1 = ~r1;
            step("rand", r0, r1, 16'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of each requester data port and the shared output.
REQ-002 Parameter MAX_HOLD, default 8, max consecutive grant cycles before forced handoff when the other side is waiting; legal range 2..255.
REQ-003 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset; one clock, asynchronous, active-high.
REQ-005 Port req0  input  1  requester 0 wants the shared 16-bit path; held high for the whole transfer.
REQ-006 Port req1  input  1  requester 1 wants the shared path; same rules as req0.
REQ-007 Port data0  input  DATA_WIDTH  requester 0 payload, selected when select=0.
REQ-008 Port data1  input  DATA_WIDTH  requester 1 payload, selected when select=1.
REQ-009 Port gnt0  output  1  registered grant to requester 0.
REQ-010 Port gnt1  output  1  registered grant to requester 1.
REQ-011 Port select  output  1  registered mux select; 0 = data0, 1 = data1.
REQ-012 Port out  output  DATA_WIDTH  shared path, combinational: select ? data1 : data0.
REQ-013 Port out_valid  output  1  combinational: (gnt0 & req0) | (gnt1 & req1).
REQ-014 Port hold_cnt  output  8  registered count of cycles the current grant has been held.

Function
REQ-015 FSM states: IDLE, GRANT0, GRANT1; gnt0=1 only in GRANT0, gnt1=1 only in GRANT1; never both high.
REQ-016 Register last_srv (1 bit) records the requester most recently granted.
REQ-017 IDLE: only req0 -> GRANT0; only req1 -> GRANT1; both -> grant the requester != last_srv; neither -> stay IDLE.
REQ-018 Grant latency: req sampled high at edge N in IDLE -> gnt high after edge N (one cycle).
REQ-019 On entering GRANTx: select=x, last_srv=x, hold_cnt=1.
REQ-020 In GRANTx with reqx high: hold_cnt increments by 1 per cycle, saturating at MAX_HOLD.
REQ-021 In GRANTx, reqx low: other req high -> go directly to other grant state (no IDLE bubble); else -> IDLE.
REQ-022 In GRANTx, reqx high, hold_cnt == MAX_HOLD and other req high -> forced handoff to the other grant state next edge.
REQ-023 In GRANTx, reqx high, other req low -> remain in GRANTx indefinitely; hold_cnt stays saturated at MAX_HOLD.
REQ-024 IDLE: select holds its last value; hold_cnt = 0.
REQ-025 Requester drops req within one cycle after losing gnt; a req held high after forced handoff is re-arbitrated as a new request.
REQ-026 Simultaneous release of reqx and assertion of the other req in the same cycle -> handoff per REQ-021.
REQ-027 out and out_valid track data/req changes combinationally within the cycle.

Reset
REQ-028 rst high forces state=IDLE, gnt0=0, gnt1=0, select=0, last_srv=1 (requester 0 wins first tie), hold_cnt=0, immediately without waiting for clk.
REQ-029 rst asserted mid-grant aborts the transfer; after release, arbitration restarts from IDLE on the next edge with pending reqs.
REQ-030 Outputs remain at reset values while rst is high regardless of req inputs.

Verification
REQ-031 Reset, then req0=1 only, data0=16'hA5A5 -> next cycle gnt0=1, select=0, out=16'hA5A5, out_valid=1, hold_cnt=1.
REQ-032 From IDLE after reset, req0=req1=1 same edge -> gnt0 first; drop req0 -> gnt1=1 on next edge with no IDLE cycle, select=1.
REQ-033 MAX_HOLD=8, req0 held, req1 raised at hold_cnt=3 -> gnt0 for exactly 8 cycles, then gnt1=1, hold_cnt=1.
REQ-034 req1 alone held 20 cycles -> gnt1 stays high, hold_cnt saturates at 8, no toggle.
REQ-035 rst pulsed asynchronously (between edges) during GRANT1 -> gnt1, select, hold_cnt go to 0 before next edge; with req0 high after release -> gnt0 one edge later.
REQ-036 Random req0/req1 stream for 10k cycles -> assertions: gnt0 & gnt1 never 1; select matches active grant; no requester waits more than MAX_HOLD+2 cycles.
